jzjpcc_decode_hazard: RTL and testbench
=======================================

# jzjpcc_decode_hazard

Decode-to-execute pipeline register with operand forwarding, load-use interlock, downstream hold and flush. It sits between the fetch stage and the execute stage, in place of the plain decode register. It replaces the pass-through register file operands with values bypassed from `NUM_FWD` later pipeline stages. It also inserts bubbles itself when a load result cannot yet be forwarded.

## Interface
Parameters:
- `PC_MAX_B`, 31: MSB of the word-aligned PC; PC fields are `[PC_MAX_B:2]`.
- `NUM_FWD`, 2: number of forwarding sources; index 0 is the youngest and has the highest priority.
- `CNT_W`, 16: width of the saturating stall counter.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `instruction_decode`  in  [31:2]: instruction from fetch.
- `currentPC_decode`  in  [PC_MAX_B:2]: PC of `instruction_decode`.
- `valid_decode`  in  1: the decode slot holds a real instruction.
- `rs1Addr_decode`, `rs2Addr_decode`  out  5: equal to `instruction_decode[19:15]` and `[24:20]`; combinational.
- `rs1_decode`, `rs2_decode`  in  32: register file read data.
- `fwdValid`  in  NUM_FWD: the source writes rd this cycle.
- `fwdAddr`  in  NUM_FWD×5: destination register of each source.
- `fwdData`  in  NUM_FWD×32: result of each source.
- `holdExecute`  in  1: downstream is busy, so freeze the execute register.
- `flush_execute`  in  1: kill the instruction entering execute.
- `stall_decode`  out  1: fetch must hold PC and `instruction_decode`; combinational.
- `instruction_execute`  out  [31:2]: registered instruction.
- `currentPC_execute`  out  [PC_MAX_B:2]: registered PC.
- `rs1_execute`, `rs2_execute`  out  32: forwarded operands, registered.
- `rdAddr_execute`  out  5: registered `instruction[11:7]`.
- `valid_execute`  out  1: execute slot is live.
- `isLoad_execute`  out  1: opcode `[6:2]` is `5'b00000`.
- `stallCount`  out  CNT_W: cycles spent in interlock or hold; saturates.

## Operation
Forwarding (combinational, per operand):
- Take the lowest index `i` with `fwdValid[i]`, `fwdAddr[i] == rsN`, and `rsN != 0`.
- If such an `i` exists, use `fwdData[i]`; otherwise use `rsN_decode`.
- Register x0 always reads 0 regardless of its input.

Load-use hazard:
- `loadUse` = `valid_execute && isLoad_execute && rdAddr_execute != 0 && valid_decode && (rdAddr_execute == rs1Addr_decode || rdAddr_execute == rs2Addr_decode)`.
- The rs comparison is conservative: both fields are compared irrespective of format.
- `stall_decode` = `loadUse || holdExecute`.

Register update, in priority order, evaluated each rising edge:
1. `reset`: all outputs go to 0, including `valid_execute` and `stallCount`.
2. `flush_execute`: `valid_execute` ← 0; `rdAddr_execute` ← 0; other fields are don't-care but are loaded normally. Flush overrides hold.
3. `holdExecute`: all execute registers keep their values.
4. `loadUse`: insert a bubble. `valid_execute` ← 0, `rdAddr_execute` ← 0, `isLoad_execute` ← 0. The decode instruction stays put because fetch is stalled.
5. Otherwise advance:
   - `valid_execute` ← `valid_decode`.
   - All fields load from decode.
   - `rdAddr_execute` is forced to 0 when `valid_decode` is 0.

Stall counter:
- `stallCount` increments on every non-reset edge where `stall_decode` is 1.
- It saturates at all ones and never wraps.

## Timing
- Latency is 1 cycle from decode to execute.
- Forwarding and `stall_decode` are combinational from the inputs and the current execute state. No registered-path loop exists.
- A load-use hazard costs exactly one bubble. On the next cycle the execute slot is invalid, so `loadUse` drops and the instruction advances. Its operand is then taken from the forwarding source that carries the load result.
- If `holdExecute` is asserted during a load-use hazard, hold wins. The bubble is inserted on the first edge with hold deasserted.
- Reset mid-operation clears the slot immediately (asynchronous). The first edge after release advances normally.

## Structure
- Shared package `jzjpcc_pkg` holds:
  - `OPCODE_LOAD = 5'b00000`.
  - The nop rd constant `5'd0`.
  - typedef `fwd_src_t` {valid, addr[4:0], data[31:0]}.
- One sub-module, `jzjpcc_forwardMux`, resolves one operand: priority select over `NUM_FWD` sources with the x0 rule. It is instantiated twice.

## Test plan
- **Reset:** assert `reset` mid-stream → all outputs read 0 within the same cycle; `stallCount` = 0.
- **Forward priority:**
  - Stimulus: `add x5,x1,x2` with x1 valid in both sources, `fwdData[0]=0xAAAA0000` and `fwdData[1]=0x1111`.
  - Response: `rs1_execute=0xAAAA0000`, `rs2_execute=rs2_decode`.
  - Also: `rs1Addr=0` with a source claiming x0 → operand 0.
- **Load-use:**
  - Stimulus: `lw x3,0(x1)` followed by `add x4,x3,x3`.
  - Response: `stall_decode=1` for exactly 1 cycle; a bubble appears (`valid_execute=0`, `rdAddr=0`); the add issues next cycle; `stallCount=1`.
- **No false hazard:** `lw x0,...` followed by a use of x0 → no stall.
- **Hold + flush:**
  - Stimulus: `holdExecute` for 3 cycles → execute registers unchanged, `stallCount=3`.
  - Then `flush_execute` and `holdExecute` together → `valid_execute=0`, `rdAddr_execute=0`.
- **Saturation:** `CNT_W=2` with hold asserted for 5 cycles → `stallCount` = 3, no wrap.

Source files
------------

// File: rtl/jzjpcc_pkg.sv
// Shared constants and types for the jzjpcc decode/execute boundary.
package jzjpcc_pkg;

    localparam logic [4:0] OPCODE_LOAD = 5'b00000;
    localparam logic [4:0] NOP_RD      = 5'd0;

    typedef struct packed {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
    } fwd_src_t;

endpackage

// File: rtl/jzjpcc_forwardMux.sv
// Resolves one source operand: youngest matching forwarding source wins,
// otherwise register file data; x0 always reads zero.
module jzjpcc_forwardMux
    import jzjpcc_pkg::*;
#(
    parameter int NUM_FWD = 2
) (
    input  logic [4:0]                 i_rsAddr,
    input  logic [31:0]                i_regData,
    input  fwd_src_t [NUM_FWD-1:0]     i_src,
    output logic [31:0]                o_data
);

    // Walk from oldest to youngest so the lowest index overrides last.
    always_comb begin
        o_data = i_regData;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (i_src[i].valid && (i_src[i].addr == i_rsAddr))
                o_data = i_src[i].data;
        end
        if (i_rsAddr == 5'd0)
            o_data = 32'd0;
    end

endmodule

// File: rtl/jzjpcc_decode_hazard.sv
// Decode-to-execute register with operand bypass, load-use bubble insertion,
// downstream hold, flush and a saturating stall counter.
module jzjpcc_decode_hazard
    import jzjpcc_pkg::*;
#(
    parameter int PC_MAX_B = 31,
    parameter int NUM_FWD  = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:2]               instruction_decode,
    input  logic [PC_MAX_B:2]         currentPC_decode,
    input  logic                      valid_decode,
    output logic [4:0]                rs1Addr_decode,
    output logic [4:0]                rs2Addr_decode,
    input  logic [31:0]               rs1_decode,
    input  logic [31:0]               rs2_decode,
    input  logic [NUM_FWD-1:0]        fwdValid,
    input  logic [NUM_FWD-1:0][4:0]   fwdAddr,
    input  logic [NUM_FWD-1:0][31:0]  fwdData,
    input  logic                      holdExecute,
    input  logic                      flush_execute,
    output logic                      stall_decode,
    output logic [31:2]               instruction_execute,
    output logic [PC_MAX_B:2]         currentPC_execute,
    output logic [31:0]               rs1_execute,
    output logic [31:0]               rs2_execute,
    output logic [4:0]                rdAddr_execute,
    output logic                      valid_execute,
    output logic                      isLoad_execute,
    output logic [CNT_W-1:0]          stallCount
);

    logic [31:2]           r_instr;
    logic [PC_MAX_B:2]     r_pc;
    logic [31:0]           r_rs1;
    logic [31:0]           r_rs2;
    logic [4:0]            r_rd;
    logic                  r_valid;
    logic                  r_isLoad;
    logic [CNT_W-1:0]      r_cnt;

    fwd_src_t [NUM_FWD-1:0] w_src;
    logic [31:0]           w_rs1;
    logic [31:0]           w_rs2;
    logic                  w_loadUse;
    logic                  w_isLoadDec;
    logic [4:0]            w_rdDec;

    assign rs1Addr_decode = instruction_decode[19:15];
    assign rs2Addr_decode = instruction_decode[24:20];
    assign w_isLoadDec    = (instruction_decode[6:2] == OPCODE_LOAD);
    assign w_rdDec        = valid_decode ? instruction_decode[11:7] : NOP_RD;

    always_comb begin
        w_src = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            w_src[i].valid = fwdValid[i];
            w_src[i].addr  = fwdAddr[i];
            w_src[i].data  = fwdData[i];
        end
    end

    jzjpcc_forwardMux #(.NUM_FWD(NUM_FWD)) u_fwd_rs1 (
        .i_rsAddr  (rs1Addr_decode),
        .i_regData (rs1_decode),
        .i_src     (w_src),
        .o_data    (w_rs1)
    );

    jzjpcc_forwardMux #(.NUM_FWD(NUM_FWD)) u_fwd_rs2 (
        .i_rsAddr  (rs2Addr_decode),
        .i_regData (rs2_decode),
        .i_src     (w_src),
        .o_data    (w_rs2)
    );

    // Both rs fields are compared regardless of format; a spurious match only
    // costs one bubble.
    assign w_loadUse = r_valid && r_isLoad && (r_rd != NOP_RD) && valid_decode &&
                       ((r_rd == rs1Addr_decode) || (r_rd == rs2Addr_decode));

    assign stall_decode = w_loadUse || holdExecute;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_instr  <= '0;
            r_pc     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= NOP_RD;
            r_valid  <= 1'b0;
            r_isLoad <= 1'b0;
        end else if (flush_execute) begin
            r_instr  <= instruction_decode;
            r_pc     <= currentPC_decode;
            r_rs1    <= w_rs1;
            r_rs2    <= w_rs2;
            r_rd     <= NOP_RD;
            r_valid  <= 1'b0;
            r_isLoad <= w_isLoadDec;
        end else if (!holdExecute) begin
            if (w_loadUse) begin
                r_rd     <= NOP_RD;
                r_valid  <= 1'b0;
                r_isLoad <= 1'b0;
            end else begin
                r_instr  <= instruction_decode;
                r_pc     <= currentPC_decode;
                r_rs1    <= w_rs1;
                r_rs2    <= w_rs2;
                r_rd     <= w_rdDec;
                r_valid  <= valid_decode;
                r_isLoad <= w_isLoadDec;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (stall_decode && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign instruction_execute = r_instr;
    assign currentPC_execute   = r_pc;
    assign rs1_execute         = r_rs1;
    assign rs2_execute         = r_rs2;
    assign rdAddr_execute      = r_rd;
    assign valid_execute       = r_valid;
    assign isLoad_execute      = r_isLoad;
    assign stallCount          = r_cnt;

endmodule

// File: tb/tb_jzjpcc_decode_hazard.sv
// Directed bench for jzjpcc_decode_hazard: a vector table for forwarding and
// advance behaviour, then hand sequences for load-use, reset, hold, flush, saturation.
module tb_jzjpcc_decode_hazard;

    logic               clock = 1'b0;
    logic               reset;
    logic [31:2]        instruction_decode;
    logic [31:2]        currentPC_decode;
    logic               valid_decode;
    logic [4:0]         rs1Addr_decode, rs2Addr_decode;
    logic [31:0]        rs1_decode, rs2_decode;
    logic [1:0]         fwdValid;
    logic [1:0][4:0]    fwdAddr;
    logic [1:0][31:0]   fwdData;
    logic               holdExecute, flush_execute;
    logic               stall_decode;
    logic [31:2]        instruction_execute;
    logic [31:2]        currentPC_execute;
    logic [31:0]        rs1_execute, rs2_execute;
    logic [4:0]         rdAddr_execute;
    logic               valid_execute, isLoad_execute;
    logic [15:0]        stallCount;

    logic [4:0]         s_rs1A, s_rs2A;
    logic               s_stall;
    logic [31:2]        s_instr, s_pc;
    logic [31:0]        s_rs1, s_rs2;
    logic [4:0]         s_rd;
    logic               s_valid, s_isLoad;
    logic [1:0]         s_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    jzjpcc_decode_hazard #(.PC_MAX_B(31), .NUM_FWD(2), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .instruction_decode(instruction_decode), .currentPC_decode(currentPC_decode),
        .valid_decode(valid_decode),
        .rs1Addr_decode(rs1Addr_decode), .rs2Addr_decode(rs2Addr_decode),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
        .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData),
        .holdExecute(holdExecute), .flush_execute(flush_execute),
        .stall_decode(stall_decode),
        .instruction_execute(instruction_execute), .currentPC_execute(currentPC_execute),
        .rs1_execute(rs1_execute), .rs2_execute(rs2_execute),
        .rdAddr_execute(rdAddr_execute), .valid_execute(valid_execute),
        .isLoad_execute(isLoad_execute), .stallCount(stallCount)
    );

    // Narrow-counter copy sharing all inputs, used for the saturation check.
    jzjpcc_decode_hazard #(.PC_MAX_B(31), .NUM_FWD(2), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset),
        .instruction_decode(instruction_decode), .currentPC_decode(currentPC_decode),
        .valid_decode(valid_decode),
        .rs1Addr_decode(s_rs1A), .rs2Addr_decode(s_rs2A),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
        .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData),
        .holdExecute(holdExecute), .flush_execute(flush_execute),
        .stall_decode(s_stall),
        .instruction_execute(s_instr), .currentPC_execute(s_pc),
        .rs1_execute(s_rs1), .rs2_execute(s_rs2),
        .rdAddr_execute(s_rd), .valid_execute(s_valid),
        .isLoad_execute(s_isLoad), .stallCount(s_cnt)
    );

    typedef struct {
        logic [31:0] ins;
        logic        vld;
        logic [31:0] r1, r2;
        logic [1:0]  fv;
        logic [4:0]  fa0, fa1;
        logic [31:0] fd0, fd1;
        logic        e_stall;
        logic        e_vld;
        logic [4:0]  e_rd;
        logic [31:0] e_r1, e_r2;
        logic        e_ld;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    function automatic logic [31:0] lw_i(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'h03};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [31:0] ins, input logic v, input logic [31:0] r1,
                       input logic [31:0] r2);
        instruction_decode = ins[31:2];
        valid_decode       = v;
        rs1_decode         = r1;
        rs2_decode         = r2;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc;

        //            ins             vld r1     r2     fv     fa0 fa1 fd0           fd1         stl vld rd  e_r1          e_r2      ld
        tbl[0] = '{add_i(5, 1, 2),   1, 32'h11, 32'h22, 2'b11, 1, 1, 32'hAAAA0000, 32'h1111, 0, 1, 5,  32'hAAAA0000, 32'h22,   0};
        tbl[1] = '{add_i(6, 0, 3),   1, 32'h55, 32'h33, 2'b01, 0, 0, 32'hDEAD,     32'h0,    0, 1, 6,  32'h0,        32'h33,   0};
        tbl[2] = '{add_i(7, 2, 9),   1, 32'h44, 32'h0,  2'b10, 9, 9, 32'h77,       32'h99,   0, 1, 7,  32'h44,       32'h99,   0};
        tbl[3] = '{add_i(8, 4, 4),   1, 32'h1,  32'h2,  2'b11, 3, 4, 32'h3333,     32'h4444, 0, 1, 8,  32'h4444,     32'h4444, 0};
        tbl[4] = '{add_i(9, 1, 2),   0, 32'h1,  32'h2,  2'b00, 0, 0, 32'h0,        32'h0,    0, 0, 0,  32'h1,        32'h2,    0};
        tbl[5] = '{lw_i(0, 1),       1, 32'h10, 32'h20, 2'b00, 0, 0, 32'h0,        32'h0,    0, 1, 0,  32'h10,       32'h0,    1};
        tbl[6] = '{add_i(10, 0, 0),  1, 32'h7,  32'h8,  2'b00, 0, 0, 32'h0,        32'h0,    0, 1, 10, 32'h0,        32'h0,    0};

        reset = 1'b1;
        put(32'h0, 1'b0, 32'h0, 32'h0);
        currentPC_decode = '0;
        fwdValid = '0; fwdAddr = '0; fwdData = '0;
        holdExecute = 1'b0; flush_execute = 1'b0;
        tick();
        tick();
        chk("reset_valid", 32'(valid_execute), 32'h0);
        chk("reset_cnt",   32'(stallCount),    32'h0);
        reset = 1'b0;

        for (int k = 0; k < 7; k++) begin
            pc = 32'h1000 + 32'(k) * 4;
            put(tbl[k].ins, tbl[k].vld, tbl[k].r1, tbl[k].r2);
            currentPC_decode = pc[31:2];
            fwdValid   = tbl[k].fv;
            fwdAddr[0] = tbl[k].fa0; fwdAddr[1] = tbl[k].fa1;
            fwdData[0] = tbl[k].fd0; fwdData[1] = tbl[k].fd1;
            #1;
            chk($sformatf("v%0d_rs1Addr", k), 32'(rs1Addr_decode), 32'(tbl[k].ins[19:15]));
            chk($sformatf("v%0d_stall", k),   32'(stall_decode),   32'(tbl[k].e_stall));
            tick();
            chk($sformatf("v%0d_valid", k),  32'(valid_execute),       32'(tbl[k].e_vld));
            chk($sformatf("v%0d_rd", k),     32'(rdAddr_execute),      32'(tbl[k].e_rd));
            chk($sformatf("v%0d_rs1", k),    rs1_execute,              tbl[k].e_r1);
            chk($sformatf("v%0d_rs2", k),    rs2_execute,              tbl[k].e_r2);
            chk($sformatf("v%0d_isLoad", k), 32'(isLoad_execute),      32'(tbl[k].e_ld));
            chk($sformatf("v%0d_instr", k),  32'(instruction_execute), 32'(tbl[k].ins[31:2]));
            chk($sformatf("v%0d_pc", k),     32'(currentPC_execute),   32'(pc[31:2]));
        end
        chk("table_cnt", 32'(stallCount), 32'h0);
        fwdValid = '0;

        // Load-use: lw x3 then add x4,x3,x3 -> one bubble, then forwarded issue.
        put(lw_i(3, 1), 1'b1, 32'h100, 32'h0);
        tick();
        chk("lu_lw_isLoad", 32'(isLoad_execute), 32'h1);
        chk("lu_lw_rd",     32'(rdAddr_execute), 32'h3);
        put(add_i(4, 3, 3), 1'b1, 32'h5, 32'h5);
        #1 chk("lu_stall_hi", 32'(stall_decode), 32'h1);
        tick();
        chk("lu_bub_valid",  32'(valid_execute),  32'h0);
        chk("lu_bub_rd",     32'(rdAddr_execute), 32'h0);
        chk("lu_bub_isLoad", 32'(isLoad_execute), 32'h0);
        chk("lu_cnt",        32'(stallCount),     32'h1);
        #1 chk("lu_stall_lo", 32'(stall_decode), 32'h0);
        fwdValid = 2'b01; fwdAddr[0] = 5'd3; fwdData[0] = 32'hCAFE;
        tick();
        chk("lu_add_valid", 32'(valid_execute),  32'h1);
        chk("lu_add_rd",    32'(rdAddr_execute), 32'h4);
        chk("lu_add_rs1",   rs1_execute,         32'hCAFE);
        chk("lu_add_rs2",   rs2_execute,         32'hCAFE);
        chk("lu_cnt_after", 32'(stallCount),     32'h1);
        fwdValid = '0;

        // Asynchronous reset mid-cycle clears the slot without a clock edge.
        #1 reset = 1'b1;
        #1;
        chk("ares_valid", 32'(valid_execute),       32'h0);
        chk("ares_rd",    32'(rdAddr_execute),      32'h0);
        chk("ares_rs1",   rs1_execute,              32'h0);
        chk("ares_instr", 32'(instruction_execute), 32'h0);
        chk("ares_cnt",   32'(stallCount),          32'h0);
        #1 reset = 1'b0;
        put(add_i(12, 1, 2), 1'b1, 32'h12, 32'h34);
        tick();
        chk("post_res_valid", 32'(valid_execute),  32'h1);
        chk("post_res_rd",    32'(rdAddr_execute), 32'hC);
        chk("post_res_rs1",   rs1_execute,         32'h12);

        // Hold for three cycles: execute frozen, counter counts.
        put(add_i(13, 1, 2), 1'b1, 32'h99, 32'h98);
        holdExecute = 1'b1;
        for (int h = 0; h < 3; h++) begin
            #1 chk($sformatf("hold%0d_stall", h), 32'(stall_decode), 32'h1);
            tick();
            chk($sformatf("hold%0d_rd", h),  32'(rdAddr_execute), 32'hC);
            chk($sformatf("hold%0d_rs1", h), rs1_execute,         32'h12);
        end
        chk("hold_cnt", 32'(stallCount), 32'h3);
        flush_execute = 1'b1;
        tick();
        chk("flush_valid", 32'(valid_execute),       32'h0);
        chk("flush_rd",    32'(rdAddr_execute),      32'h0);
        chk("flush_instr", 32'(instruction_execute), 32'(add_i(13, 1, 2) >> 2));
        chk("flush_cnt",   32'(stallCount),          32'h4);
        flush_execute = 1'b0;
        holdExecute   = 1'b0;

        // Hold during a load-use hazard: hold wins, bubble follows.
        pulse_reset();
        put(lw_i(3, 1), 1'b1, 32'h0, 32'h0);
        tick();
        put(add_i(4, 3, 3), 1'b1, 32'h0, 32'h0);
        holdExecute = 1'b1;
        tick();
        chk("hlu_held_rd",     32'(rdAddr_execute), 32'h3);
        chk("hlu_held_isLoad", 32'(isLoad_execute), 32'h1);
        holdExecute = 1'b0;
        tick();
        chk("hlu_bub_valid", 32'(valid_execute), 32'h0);
        chk("hlu_cnt",       32'(stallCount),    32'h2);
        tick();
        chk("hlu_add_rd", 32'(rdAddr_execute), 32'h4);

        // No false hazard on x0 load destination is covered in the table (v5->v6).
        // Saturation: five held cycles on a 2-bit counter.
        pulse_reset();
        put(32'h0, 1'b0, 32'h0, 32'h0);
        holdExecute = 1'b1;
        repeat (5) tick();
        chk("sat_narrow", 32'(s_cnt),      32'h3);
        chk("sat_wide",   32'(stallCount), 32'h5);
        holdExecute = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
